// File: rtl/capture_readout.sv
// Read-side controller for the sample-capture BRAM: on a start edge while the
// BRAM is full, streams addresses 0..MAX_COUNT-1 out over a valid/ready port.
module capture_readout #(
    parameter int NB_ADDR   = 15,
    parameter int NB_DATA   = 14,
    parameter int MAX_COUNT = 2047
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_mem_full,
    output logic [NB_ADDR-1:0] o_read_addr,
    output logic               o_read_enable,
    input  logic [NB_DATA-1:0] i_read_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        PRESENT,
        DONE
    } state_t;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MAX_COUNT - 1);

    state_t             state;
    state_t             state_next;
    logic [NB_ADDR-1:0] addr;
    logic [NB_ADDR-1:0] addr_next;
    logic               start_d;
    logic               start_pulse;
    logic [NB_DATA-1:0] data_q;

    assign start_pulse = i_start && !start_d;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state   <= IDLE;
            addr    <= '0;
            start_d <= 1'b0;
            data_q  <= '0;
        end else begin
            state   <= state_next;
            addr    <= addr_next;
            start_d <= i_start;
            if (state == WAIT) begin
                data_q <= i_read_data;
            end
        end
    end

    // addr only moves on entry to READ, so it doubles as the held read address
    always_comb begin
        state_next = state;
        addr_next  = addr;
        if (i_abort && state != IDLE) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_pulse && i_mem_full) begin
                        state_next = READ;
                        addr_next  = '0;
                    end
                end
                READ:    state_next = WAIT;
                WAIT:    state_next = PRESENT;
                PRESENT: begin
                    if (i_ready) begin
                        if (addr == LAST_ADDR) begin
                            state_next = DONE;
                        end else begin
                            addr_next  = addr + NB_ADDR'(1);
                            state_next = READ;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign o_read_addr   = addr;
    assign o_read_enable = (state == READ);
    assign o_data        = data_q;
    assign o_valid       = (state == PRESENT);
    assign o_busy        = (state != IDLE);
    assign o_done        = (state == DONE);

endmodule

// File: tb/tb_capture_readout.sv
// Bench for capture_readout: transaction-level model checked every cycle, plus
// literal timing/sequence expectations for the directed scenarios.
module tb_capture_readout;

    localparam int NB_ADDR = 15;
    localparam int NB_DATA = 14;
    localparam int MAXC    = 8;

    logic               clock      = 1'b0;
    logic               i_reset    = 1'b1;
    logic               i_start    = 1'b0;
    logic               i_abort    = 1'b0;
    logic               i_mem_full = 1'b1;
    logic               i_ready    = 1'b1;
    logic [NB_ADDR-1:0] o_read_addr;
    logic               o_read_enable;
    logic [NB_DATA-1:0] i_read_data;
    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic               o_busy;
    logic               o_done;

    logic [NB_DATA-1:0] mem [0:MAXC-1];
    logic [NB_DATA-1:0] mem_q = '0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int                 xfer_t [$];
    logic [NB_DATA-1:0] xfer_d [$];
    int                 raddr_q [$];
    int                 done_t [$];

    // model: an active readout fetching sample m_idx, m_wait cycles until it is shown
    bit m_active = 0;
    bit m_done   = 0;
    int m_wait   = 0;
    int m_idx    = 0;
    int m_addr   = 0;
    bit m_sprev  = 0;

    capture_readout #(
        .NB_ADDR  (NB_ADDR),
        .NB_DATA  (NB_DATA),
        .MAX_COUNT(MAXC)
    ) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_mem_full   (i_mem_full),
        .o_read_addr  (o_read_addr),
        .o_read_enable(o_read_enable),
        .i_read_data  (i_read_data),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (o_read_enable) mem_q <= mem[o_read_addr[2:0]];
    end
    assign i_read_data = mem_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        bit sp;
        @(posedge clock);
        cyc++;
        if (!i_reset) begin
            m_active = 0; m_done = 0; m_wait = 0; m_idx = 0; m_addr = 0; m_sprev = 0;
        end else begin
            if (o_valid && i_ready && !i_abort) begin
                xfer_t.push_back(cyc);
                xfer_d.push_back(o_data);
            end
            if (o_read_enable) raddr_q.push_back(int'(o_read_addr));
            if (o_done) done_t.push_back(cyc);
            sp = i_start && !m_sprev;
            m_sprev = i_start;
            if (m_done) begin
                m_done = 0;
            end else if (m_active) begin
                if (i_abort) m_active = 0;
                else if (m_wait > 0) m_wait--;
                else if (i_ready) begin
                    if (m_idx == MAXC - 1) begin
                        m_active = 0;
                        m_done   = 1;
                    end else begin
                        m_idx++;
                        m_addr = m_idx;
                        m_wait = 2;
                    end
                end
            end else if (sp && i_mem_full) begin
                m_active = 1; m_idx = 0; m_addr = 0; m_wait = 2;
            end
        end
    end

    initial forever begin
        @(posedge clock);
        #1;
        chk("busy",    o_busy,        32'(m_active || m_done));
        chk("valid",   o_valid,       32'(m_active && m_wait == 0));
        chk("rd_en",   o_read_enable, 32'(m_active && m_wait == 2));
        chk("rd_addr", o_read_addr,   m_addr);
        chk("done",    o_done,        32'(m_done));
        if (m_active && m_wait == 0) chk("data", o_data, mem[m_idx]);
        if (!i_reset) chk("data_rst", o_data, 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_logs();
        xfer_t.delete(); xfer_d.delete(); raddr_q.delete(); done_t.delete();
    endtask

    task automatic start_edge(output int n);
        @(negedge clock);
        i_start = 1'b1;
        n = cyc + 1;
        tick(1);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_t.size() == 0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("done_timeout", 32'(done_t.size() != 0), 1);
        tick(2);
    endtask

    task automatic wait_valid_data(input logic [NB_DATA-1:0] d, input int budget);
        int k = 0;
        while (!(o_valid && o_data == d) && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("valid_timeout", 32'(o_valid && o_data == d), 1);
    endtask

    // full 8-sample readout with optional stall of hold_n cycles starting at sample hold_k
    task automatic check_run(input string tag, input int n, input int hold_k, input int hold_n);
        chk({tag, "_nxfer"}, xfer_t.size(), MAXC);
        for (int k = 0; k < MAXC && k < xfer_t.size(); k++) begin
            chk({tag, "_xdata"}, xfer_d[k], 32'h100 + k);
            chk({tag, "_xtime"}, xfer_t[k], n + 3 + 3 * k + (k >= hold_k ? hold_n : 0));
        end
        chk({tag, "_ndone"}, done_t.size(), 1);
        if (done_t.size() > 0) chk({tag, "_dtime"}, done_t[0], n + 25 + hold_n);
        chk({tag, "_nraddr"}, raddr_q.size(), MAXC);
        for (int k = 0; k < MAXC && k < raddr_q.size(); k++) chk({tag, "_raddr"}, raddr_q[k], k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int saved;
        for (int a = 0; a < MAXC; a++) mem[a] = NB_DATA'(14'h100 + a);

        #1 i_reset = 1'b0;
        #1;
        chk("rst_addr",  o_read_addr,   0);
        chk("rst_en",    o_read_enable, 0);
        chk("rst_data",  o_data,        0);
        chk("rst_valid", o_valid,       0);
        chk("rst_busy",  o_busy,        0);
        chk("rst_done",  o_done,        0);
        @(negedge clock);
        i_reset = 1'b1;
        tick(2);

        clear_logs();
        start_edge(n);
        wait_done(100);
        check_run("basic", n, MAXC, 0);

        clear_logs();
        start_edge(n);
        wait_valid_data(14'h103, 50);
        i_ready = 1'b0;
        tick(5);
        i_ready = 1'b1;
        wait_done(100);
        check_run("bp", n, 3, 5);

        clear_logs();
        i_mem_full = 1'b0;
        @(negedge clock);
        i_start = 1'b1;
        tick(6);
        chk("gate_busy", o_busy, 0);
        chk("gate_rd", raddr_q.size(), 0);
        i_mem_full = 1'b1;
        tick(6);
        chk("gate_busy2", o_busy, 0);
        chk("gate_rd2", raddr_q.size(), 0);
        i_start = 1'b0;
        tick(1);
        start_edge(n);
        wait_done(100);
        check_run("gate", n, MAXC, 0);

        clear_logs();
        start_edge(n);
        wait_valid_data(14'h104, 50);
        i_abort = 1'b1;
        tick(1);
        i_abort = 1'b0;
        chk("abort_valid", o_valid, 0);
        chk("abort_busy", o_busy, 0);
        tick(5);
        chk("abort_nxfer", xfer_t.size(), 4);
        chk("abort_ndone", done_t.size(), 0);
        clear_logs();
        start_edge(n);
        wait_done(100);
        check_run("restart", n, MAXC, 0);

        clear_logs();
        start_edge(n);
        for (int k = 0; k < 50 && !(o_read_enable && o_read_addr == 2); k++) @(negedge clock);
        chk("rst_wait_timeout", 32'(o_read_enable && o_read_addr == 2), 1);
        tick(1);
        i_reset = 1'b0;
        #1;
        chk("mrst_addr",  o_read_addr,   0);
        chk("mrst_en",    o_read_enable, 0);
        chk("mrst_data",  o_data,        0);
        chk("mrst_valid", o_valid,       0);
        chk("mrst_busy",  o_busy,        0);
        chk("mrst_done",  o_done,        0);
        tick(2);
        i_reset = 1'b1;
        saved = raddr_q.size();
        tick(8);
        chk("mrst_quiet_rd", raddr_q.size(), saved);
        chk("mrst_quiet_busy", o_busy, 0);
        clear_logs();
        start_edge(n);
        wait_done(100);
        check_run("postrst", n, MAXC, 0);

        clear_logs();
        start_edge(n);
        for (int k = 0; k < 10; k++) begin
            i_start = 1'b1;
            tick(1);
            i_start = 1'b0;
            tick(1);
        end
        wait_done(100);
        tick(10);
        check_run("retrig", n, MAXC, 0);

        for (int r = 0; r < 4; r++) begin
            int k;
            for (int a = 0; a < MAXC; a++) mem[a] = NB_DATA'($urandom);
            clear_logs();
            i_mem_full = 1'b1;
            start_edge(n);
            k = 0;
            while (done_t.size() == 0 && k < 300) begin
                i_ready    = 1'($urandom_range(0, 1));
                i_mem_full = 1'($urandom_range(0, 1));
                @(negedge clock);
                k++;
            end
            i_ready    = 1'b1;
            i_mem_full = 1'b1;
            chk("rnd_timeout", 32'(done_t.size() != 0), 1);
            tick(2);
            chk("rnd_nxfer", xfer_t.size(), MAXC);
            for (int j = 0; j < MAXC && j < xfer_d.size(); j++) chk("rnd_xdata", xfer_d[j], mem[j]);
            chk("rnd_ndone", done_t.size(), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
